// File: rtl/lsq_index_queue_if.sv
// Dispatch-to-LSQ index allocation bus: packed load/store slot groups in,
// retire/flush controls in, back-pressure and FIFO head/occupancy out.
interface lsq_index_queue_if #(
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [31:0]   ld_indx_in;
  logic [31:0]   st_indx_in;
  logic          ld_retire;
  logic          st_retire;
  logic          flush;
  logic          stall;
  logic          ld_head_vld;
  logic [6:0]    ld_head_idx;
  logic          st_head_vld;
  logic [6:0]    st_head_idx;
  logic [CW-1:0] ld_cnt;
  logic [CW-1:0] st_cnt;

  modport master (
    output ld_indx_in, st_indx_in, ld_retire, st_retire, flush,
    input  stall, ld_head_vld, ld_head_idx, st_head_vld, st_head_idx,
           ld_cnt, st_cnt
  );

  modport slave (
    input  ld_indx_in, st_indx_in, ld_retire, st_retire, flush,
    output stall, ld_head_vld, ld_head_idx, st_head_vld, st_head_idx,
           ld_cnt, st_cnt
  );
endinterface

// File: rtl/lsq_index_queue.sv
// Load/store ROB-index queues: compacts up to four valid slots per cycle into
// two circular FIFOs (index 0 = load, 1 = store) and exposes the oldest entry.
module lsq_index_queue #(
  parameter int unsigned DEPTH = 16
) (
  input logic              clk,
  input logic              rst,
  lsq_index_queue_if.slave bus
);
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned CW    = PW + 1;
  localparam int unsigned IW    = 7;
  localparam int unsigned NSLOT = 4;

  logic [31:0]   grp  [2];
  logic [1:0]    ret;
  logic [IW-1:0] mem  [2][DEPTH];
  logic [PW-1:0] head [2];
  logic [PW-1:0] tail [2];
  logic [CW-1:0] cnt  [2];
  logic [2:0]    nvld [2];
  logic [2:0]    off  [2][NSLOT];
  logic [1:0]    pop;
  logic [1:0]    vld;
  logic          stall_int;
  logic          accept;

  assign grp[0] = bus.ld_indx_in;
  assign grp[1] = bus.st_indx_in;
  assign ret    = {bus.st_retire, bus.ld_retire};

  // Stall only from registered counts: keep room for a full four-wide group.
  assign stall_int = ((CW'(DEPTH) - cnt[0]) < CW'(NSLOT)) |
                     ((CW'(DEPTH) - cnt[1]) < CW'(NSLOT));
  assign accept    = !stall_int && !bus.flush;

  // Per-slot write offset is the count of valid slots older than it.
  always_comb begin
    for (int g = 0; g < 2; g++) begin
      nvld[g] = '0;
      for (int k = 0; k < int'(NSLOT); k++) begin
        off[g][k] = nvld[g];
        nvld[g]   = nvld[g] + 3'(grp[g][8*k+7]);
      end
      pop[g] = ret[g] && (cnt[g] != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int g = 0; g < 2; g++) begin
        head[g] <= '0;
        tail[g] <= '0;
        cnt[g]  <= '0;
      end
    end else if (bus.flush) begin
      for (int g = 0; g < 2; g++) begin
        head[g] <= '0;
        tail[g] <= '0;
        cnt[g]  <= '0;
      end
    end else begin
      for (int g = 0; g < 2; g++) begin
        if (accept) tail[g] <= tail[g] + PW'(nvld[g]);
        if (pop[g]) head[g] <= head[g] + PW'(1);
        cnt[g] <= cnt[g] + (accept ? CW'(nvld[g]) : CW'(0)) - CW'(pop[g]);
      end
    end
  end

  // Storage carries no reset; only entries between head and tail are observed.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int g = 0; g < 2; g++) begin
        for (int k = 0; k < int'(NSLOT); k++) begin
          if (grp[g][8*k+7]) mem[g][tail[g] + PW'(off[g][k])] <= grp[g][8*k +: IW];
        end
      end
    end
  end

  assign vld[0] = (cnt[0] != '0);
  assign vld[1] = (cnt[1] != '0);

  assign bus.stall       = stall_int;
  assign bus.ld_head_vld = vld[0];
  assign bus.st_head_vld = vld[1];
  assign bus.ld_head_idx = vld[0] ? mem[0][head[0]] : '0;
  assign bus.st_head_idx = vld[1] ? mem[1][head[1]] : '0;
  assign bus.ld_cnt      = cnt[0];
  assign bus.st_cnt      = cnt[1];
endmodule
